exe_dreq_stage: RTL and testbench
=================================

Name: exe_dreq_stage

Overview:
- Memory-request half of the execute stage, directly upstream of the memory stage.
- Holds one instruction in a pipeline register and issues its load/store request on the SRAM-like data bus (req/addr_ok, data_ok).
- Computes byte strobes and replicated write data, and detects misaligned accesses (ALE).
- Tracks outstanding requests so that data_ok responses belonging to flushed instructions are discarded before the memory stage sees them.

Parameters:
- BUS_WD, 160, width of the opaque payload passed through unchanged to the memory stage.
- MAX_OUTST, 2, maximum number of accepted requests still awaiting data_ok (at least 1).

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_allowin  out  1  stage can accept a new instruction this cycle
- in_bus  in  BUS_WD  opaque payload
- in_is_load  in  1  instruction is a load
- in_is_store  in  1  instruction is a store
- in_size  in  2  01 byte, 10 half, 11 word
- in_addr  in  32  effective address
- in_wdata  in  32  store data, right-aligned
- in_excp  in  1  instruction already carries an exception
- out_valid  out  1  valid to the memory stage
- out_allowin  in  1  memory stage allowin
- out_bus  out  BUS_WD  registered payload
- out_ale  out  1  misaligned access detected
- out_mem_issued  out  1  a request was issued; the memory stage must wait for data_ok
- flush  in  1  exception/ertn/refetch flush from the memory stage
- data_sram_req  out  1  request
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  00 byte, 01 half, 10 word
- data_sram_addr  out  32  address
- data_sram_wstrb  out  4  byte strobes; 0 for loads
- data_sram_wdata  out  32  replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response returned
- data_ok_valid  out  1  filtered data_ok, which the memory stage uses in place of raw data_ok

Behaviour:
- Reset (resetn=0 at a clock edge) clears valid, issued, outst_cnt and cancel_cnt.
  - After reset: data_sram_req=0, out_valid=0, in_allowin=1, data_ok_valid=0.
  - Reset mid-transaction drops all state; the bus is also reset.
- Register load: on in_valid & in_allowin, latch the payload and all in_* fields, set valid=1, clear issued.
- Flush at a clock edge sets valid=0; flush takes priority over a new load in the same cycle.
- Derived signals:
  - mem_op = is_load | is_store.
  - ale = mem_op & ((size==10 & addr[0]) | (size==11 & addr[1:0]!=0)).
- data_sram_req = valid & mem_op & ~excp & ~ale & ~issued & ~flush & (outst_cnt < MAX_OUTST).
- On data_sram_req & data_sram_addr_ok: issued <= 1.
- data_sram_req stays asserted with stable addr, size, wr, wstrb and wdata until addr_ok.
- ready_go = ~mem_op | excp | ale | issued | (data_sram_req & data_sram_addr_ok).
- in_allowin = ~valid | (ready_go & out_allowin).
- out_valid = valid & ready_go.
- out_mem_issued = issued | (data_sram_req & data_sram_addr_ok).
- out_ale = valid & ale & ~excp.
- Request encoding:
  - data_sram_size = size-1.
  - data_sram_addr = addr.
  - data_sram_wr = is_store.
- Store strobes:
  - byte: 0001<<addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- outst_cnt:
  - +1 on req&addr_ok; -1 on data_ok; both in one cycle means no change.
  - Never exceeds MAX_OUTST, never underflows.
- cancel_cnt:
  - On flush: cancel_cnt <= outst_cnt next value, i.e. every outstanding response belongs to a flushed instruction.
  - Otherwise it decrements on data_ok while nonzero.
- data_ok_valid = data_sram_data_ok & (cancel_cnt==0), evaluated on the current registered cancel_cnt.
- Flush with data_ok in the same cycle: that response is counted out of outst_cnt before the copy into cancel_cnt.
- New requests are still allowed while cancel_cnt != 0; responses return in order, so cancelled ones come first.
- An instruction with excp or ale never issues a request.

Decomposition:
- Shared mycpu.h gains:
  - size encodings;
  - an EXE_DREQ payload width macro;
  - MAX_OUTST default.
- One natural sub-module: dreq_align, a combinational block computing ale, wstrb, wdata and sram_size from size/addr/wdata.

Test Plan:
- Word store, addr 0x1004, wdata 0xAABBCCDD, addr_ok delayed 2 cycles -> req held 3 cycles, wstrb=1111, wdata=0xAABBCCDD, out_valid rises in the addr_ok cycle, out_mem_issued=1.
- Byte store to addr 0x1003, wdata 0x55 -> wstrb=1000, wdata=0x55555555, size=00. Half load at 0x1002 -> wstrb=0000, size=01, wr=0.
- Word load at 0x1002 -> no req, out_ale=1, out_valid next cycle after the load with out_allowin=1. Same with in_excp=1 -> no req, out_ale=0.
- Two loads accepted (outst_cnt=2), then flush with no data_ok -> cancel_cnt=2. Next two data_ok -> data_ok_valid=0. The third data_ok after a new load -> data_ok_valid=1.
- Flush in the same cycle as data_ok with outst_cnt=2 -> cancel_cnt=1, and that data_ok passes as data_ok_valid=1 (cancel was 0). A third request while outst_cnt=MAX_OUTST -> req held low until a data_ok.
- resetn low for 1 cycle while issued and outstanding -> all counters 0, req=0, in_allowin=1 next cycle.

Source files
------------

// File: rtl/exe_dreq_stage_pkg.sv
// Shared definitions for the execute-stage data-request slice: access size
// encodings, payload width, outstanding-request depth and the latched
// instruction fields.
package exe_dreq_stage_pkg;

    // Access size encodings as carried by the decode stage
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Opaque payload width handed to the memory stage
    localparam int EXE_DREQ_BUS_WD = 160;

    // Default number of accepted requests that may await data_ok
    localparam int EXE_DREQ_MAX_OUTST = 2;

    // Instruction fields held in the stage register alongside the payload
    typedef struct packed {
        logic        is_load;
        logic        is_store;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        excp;
    } dreq_inst_t;

    // Bus size encoding is the internal size minus one (byte=00, half=01, word=10)
    function automatic logic [1:0] sram_size_enc(input logic [1:0] size);
        return size - 2'b01;
    endfunction

endpackage

// File: rtl/exe_dreq_stage_dreq_align.sv
// Combinational alignment helper: misalignment detection, byte strobes,
// replicated store data and bus size encoding for one access.
module exe_dreq_stage_dreq_align
    import exe_dreq_stage_pkg::*;
(
    input  logic        mem_op_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic        ale_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [1:0]  sram_size_o
);

    // Decode size and low address bits into strobes, replicated data and ALE
    always_comb begin
        ale_o   = 1'b0;
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        case (size_i)
            SIZE_BYTE: begin
                ale_o   = 1'b0;
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                ale_o   = mem_op_i & addr_lo_i[0];
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SIZE_WORD: begin
                ale_o   = mem_op_i & (addr_lo_i != 2'b00);
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                ale_o   = 1'b0;
                wstrb_o = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

    assign sram_size_o = sram_size_enc(size_i);

endmodule

// File: rtl/exe_dreq_stage.sv
// Memory-request half of the execute stage. Holds one instruction, issues
// its load/store on the SRAM-like data bus, and filters data_ok responses
// that belong to instructions killed by a flush.
module exe_dreq_stage
    import exe_dreq_stage_pkg::*;
#(
    parameter int BUS_WD    = EXE_DREQ_BUS_WD,
    parameter int MAX_OUTST = EXE_DREQ_MAX_OUTST
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [BUS_WD-1:0] in_bus,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [1:0]        in_size,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic              in_excp,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic [BUS_WD-1:0] out_bus,
    output logic              out_ale,
    output logic              out_mem_issued,
    input  logic              flush,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [31:0]       data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    output logic              data_ok_valid
);

    // Counter wide enough to hold 0..MAX_OUTST
    localparam int CNT_W = (MAX_OUTST < 1) ? 1 : $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage state
    logic              valid_q,  valid_d;
    logic              issued_q, issued_d;
    logic [CNT_W-1:0]  outst_q,  outst_d;
    logic [CNT_W-1:0]  cancel_q, cancel_d;
    dreq_inst_t        inst_q,   inst_d;
    logic [BUS_WD-1:0] bus_q,    bus_d;

    // Derived per-instruction signals
    logic        mem_op_s;
    logic        ale_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_rep_s;
    logic [1:0]  sram_size_s;
    logic        req_s;
    logic        accept_s;
    logic        ready_go_s;
    logic        load_fire_s;
    logic        resp_s;

    assign mem_op_s = inst_q.is_load | inst_q.is_store;

    exe_dreq_stage_dreq_align u_align (
        .mem_op_i    (mem_op_s),
        .size_i      (inst_q.size),
        .addr_lo_i   (inst_q.addr[1:0]),
        .wdata_i     (inst_q.wdata),
        .ale_o       (ale_s),
        .wstrb_o     (wstrb_s),
        .wdata_o     (wdata_rep_s),
        .sram_size_o (sram_size_s)
    );

    // A request may be raised only for a live, clean, not-yet-issued memory op
    // while the response tracker still has room; flush withdraws it at once.
    assign req_s       = valid_q & mem_op_s & ~inst_q.excp & ~ale_s & ~issued_q
                       & ~flush & (outst_q < MAX_CNT);
    assign accept_s    = req_s & data_sram_addr_ok;
    assign ready_go_s  = ~mem_op_s | inst_q.excp | ale_s | issued_q | accept_s;
    assign in_allowin  = ~valid_q | (ready_go_s & out_allowin);
    assign load_fire_s = in_valid & in_allowin & ~flush;
    // A data_ok with nothing outstanding is ignored by the counters
    assign resp_s      = data_sram_data_ok & (outst_q != ZERO_CNT);

    assign out_valid       = valid_q & ready_go_s;
    assign out_bus         = bus_q;
    assign out_ale         = valid_q & ale_s & ~inst_q.excp;
    assign out_mem_issued  = issued_q | accept_s;

    assign data_sram_req   = req_s;
    assign data_sram_wr    = inst_q.is_store;
    assign data_sram_size  = sram_size_s;
    assign data_sram_addr  = inst_q.addr;
    assign data_sram_wstrb = inst_q.is_store ? wstrb_s : 4'b0000;
    assign data_sram_wdata = wdata_rep_s;

    // Responses are in order, so while cancel_q is nonzero the head belongs to a flushed op
    assign data_ok_valid   = data_sram_data_ok & (cancel_q == ZERO_CNT);

    // Next-state for the instruction register: flush kills, new load replaces, handoff drains
    always_comb begin
        valid_d  = valid_q;
        issued_d = issued_q;
        inst_d   = inst_q;
        bus_d    = bus_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_fire_s) begin
            valid_d = 1'b1;
        end else if (out_valid & out_allowin) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (load_fire_s) begin
            issued_d       = 1'b0;
            inst_d.is_load  = in_is_load;
            inst_d.is_store = in_is_store;
            inst_d.size     = in_size;
            inst_d.addr     = in_addr;
            inst_d.wdata    = in_wdata;
            inst_d.excp     = in_excp;
            bus_d           = in_bus;
        end else if (accept_s) begin
            issued_d = 1'b1;
        end else begin
            issued_d = issued_q;
        end
    end

    // Next-state for the outstanding and cancel counters
    always_comb begin
        outst_d  = outst_q;
        cancel_d = cancel_q;
        if (accept_s && !resp_s) begin
            outst_d = outst_q + ONE_CNT;
        end else if (!accept_s && resp_s) begin
            outst_d = outst_q - ONE_CNT;
        end else begin
            outst_d = outst_q;
        end
        // On flush every response still in flight is stale; the one returning now is already counted out
        if (flush) begin
            cancel_d = outst_d;
        end else if (data_sram_data_ok && (cancel_q != ZERO_CNT)) begin
            cancel_d = cancel_q - ONE_CNT;
        end else begin
            cancel_d = cancel_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            issued_q <= 1'b0;
            outst_q  <= ZERO_CNT;
            cancel_q <= ZERO_CNT;
            inst_q   <= '{is_load: 1'b0, is_store: 1'b0, size: 2'b00,
                          addr: 32'h0000_0000, wdata: 32'h0000_0000, excp: 1'b0};
            bus_q    <= {BUS_WD{1'b0}};
        end else begin
            valid_q  <= valid_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            cancel_q <= cancel_d;
            inst_q   <= inst_d;
            bus_q    <= bus_d;
        end
    end

endmodule

// File: tb/tb_exe_dreq_stage.sv
// Directed bench for exe_dreq_stage: a queue-based reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_exe_dreq_stage;

    localparam int BW  = 160;
    localparam int MAX = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid, in_allowin;
    logic [BW-1:0] in_bus;
    logic          in_is_load, in_is_store;
    logic [1:0]    in_size;
    logic [31:0]   in_addr, in_wdata;
    logic          in_excp;
    logic          out_valid, out_allowin;
    logic [BW-1:0] out_bus;
    logic          out_ale, out_mem_issued, flush;
    logic          data_sram_req, data_sram_wr;
    logic [1:0]    data_sram_size;
    logic [31:0]   data_sram_addr, data_sram_wdata;
    logic [3:0]    data_sram_wstrb;
    logic          data_sram_addr_ok, data_sram_data_ok, data_ok_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int bus_cnt  = 1;

    exe_dreq_stage #(.BUS_WD(BW), .MAX_OUTST(MAX)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_bus(in_bus),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_size(in_size),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_excp(in_excp),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_bus(out_bus),
        .out_ale(out_ale), .out_mem_issued(out_mem_issued), .flush(flush),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_ok_valid(data_ok_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // In-flight responses, oldest first; each entry is 1 if it belongs to a flushed op.
    bit            q[$];
    bit            m_valid = 0, m_issued = 0, m_rst_seen = 0;
    bit            m_ld = 0, m_st = 0, m_ex = 0;
    logic [1:0]    m_size = 2'b00;
    logic [31:0]   m_addr = 32'h0, m_wdata = 32'h0;
    logic [BW-1:0] m_bus = '0;

    function automatic int cancelled_cnt();
        int c = 0;
        foreach (q[i]) if (q[i]) c++;
        return c;
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model across the coming edge
    always @(negedge clk) begin : model_p
        bit          mem_op, ale, req, acc, rgo, allow, ov, dov, loaded;
        int          nbytes;
        logic [3:0]  strb;
        logic [31:0] wrep;
        logic [1:0]  bsz;
        mem_op = m_ld || m_st;
        nbytes = (m_size == 2'd0) ? 1 : (1 << (m_size - 1));
        ale    = mem_op && ((m_addr % nbytes) != 0);
        strb   = m_st ? 4'(((1 << nbytes) - 1) << m_addr[1:0]) : 4'b0000;
        wrep   = (nbytes == 1) ? m_wdata[7:0] * 32'h0101_0101 :
                 (nbytes == 2) ? m_wdata[15:0] * 32'h0001_0001 : m_wdata;
        bsz    = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
        req    = m_valid && mem_op && !m_ex && !ale && !m_issued && !flush && (q.size() < MAX);
        acc    = req && data_sram_addr_ok;
        rgo    = !mem_op || m_ex || ale || m_issued || acc;
        allow  = !m_valid || (rgo && out_allowin);
        ov     = m_valid && rgo;
        dov    = data_sram_data_ok && !(q.size() > 0 && q[0]);
        if (m_rst_seen) begin
            check("req", data_sram_req, req);
            check("in_allowin", in_allowin, allow);
            check("out_valid", out_valid, ov);
            check("out_ale", out_ale, m_valid && ale && !m_ex);
            check("data_ok_valid", data_ok_valid, dov);
            if (ov) begin
                check("out_bus", out_bus, m_bus);
                check("out_mem_issued", out_mem_issued, m_issued || acc);
            end
            if (req) begin
                check("addr", data_sram_addr, m_addr);
                check("wr", data_sram_wr, m_st);
                check("size", data_sram_size, bsz);
                check("wstrb", data_sram_wstrb, strb);
                check("wdata", data_sram_wdata, wrep);
            end
        end
        if (!resetn) begin
            q.delete();
            m_valid = 0; m_issued = 0; m_rst_seen = 1;
            m_ld = 0; m_st = 0; m_ex = 0; m_size = 2'b00;
            m_addr = 32'h0; m_wdata = 32'h0; m_bus = '0;
        end else begin
            if (data_sram_data_ok && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(1'b0);
                m_issued = 1;
            end
            loaded = 0;
            if (flush) begin
                foreach (q[i]) q[i] = 1'b1;
                m_valid = 0;
            end else if (in_valid && allow) begin
                loaded = 1;
            end else if (ov && out_allowin) begin
                m_valid = 0;
            end
            if (loaded) begin
                m_valid = 1; m_issued = 0;
                m_ld = in_is_load; m_st = in_is_store; m_ex = in_excp;
                m_size = in_size; m_addr = in_addr; m_wdata = in_wdata; m_bus = in_bus;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit ld, input bit st, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input bit ex);
        bit got = 0;
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_size = sz;
        in_addr = a; in_wdata = wd; in_excp = ex;
        in_bus = {32'(bus_cnt), 128'hC0FF_EE00_1234_5678_9ABC_DEF0_0F1E_2D3C};
        bus_cnt++;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (in_allowin) got = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!got) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic accept_now();
        data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0;
    endtask

    task automatic resp(input bit exp_valid, input string name);
        data_sram_data_ok = 1'b1; #1;
        check(name, data_ok_valid, exp_valid);
        tick(); data_sram_data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_bus = '0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_size = 2'b00; in_addr = 32'h0; in_wdata = 32'h0; in_excp = 1'b0;
        out_allowin = 1'b1; flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        tick(); tick();
        #1;
        check("rst_req", data_sram_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_allowin", in_allowin, 1'b1);
        check("rst_dok_valid", data_ok_valid, 1'b0);
        resetn = 1'b1;
        tick();

        // Word store, addr_ok delayed two cycles
        send(0, 1, 2'b11, 32'h0000_1004, 32'hAABB_CCDD, 0);
        #1;
        check("w_req1", data_sram_req, 1'b1);
        check("w_wstrb", data_sram_wstrb, 4'b1111);
        check("w_wdata", data_sram_wdata, 32'hAABB_CCDD);
        check("w_ov_wait", out_valid, 1'b0);
        tick(); #1;
        check("w_req2", data_sram_req, 1'b1);
        tick();
        data_sram_addr_ok = 1'b1; #1;
        check("w_req3", data_sram_req, 1'b1);
        check("w_ov_ack", out_valid, 1'b1);
        check("w_issued", out_mem_issued, 1'b1);
        tick(); data_sram_addr_ok = 1'b0;
        check("model_q1", q.size(), 1);
        resp(1'b1, "w_dok");

        // Byte store and half load encodings
        send(0, 1, 2'b01, 32'h0000_1003, 32'h0000_0055, 0);
        #1;
        check("b_wstrb", data_sram_wstrb, 4'b1000);
        check("b_wdata", data_sram_wdata, 32'h5555_5555);
        check("b_size", data_sram_size, 2'b00);
        accept_now();
        resp(1'b1, "b_dok");
        send(1, 0, 2'b10, 32'h0000_1002, 32'h1234_5678, 0);
        #1;
        check("h_wstrb", data_sram_wstrb, 4'b0000);
        check("h_size", data_sram_size, 2'b01);
        check("h_wr", data_sram_wr, 1'b0);
        accept_now();
        resp(1'b1, "h_dok");

        // Misaligned word load, then same with a prior exception
        send(1, 0, 2'b11, 32'h0000_1002, 32'h0, 0);
        #1;
        check("ale_req", data_sram_req, 1'b0);
        check("ale_flag", out_ale, 1'b1);
        check("ale_ov", out_valid, 1'b1);
        tick();
        send(1, 0, 2'b11, 32'h0000_1002, 32'h0, 1);
        #1;
        check("ex_req", data_sram_req, 1'b0);
        check("ex_ale", out_ale, 1'b0);
        check("ex_ov", out_valid, 1'b1);
        tick();

        // Two outstanding loads flushed; their responses are swallowed
        send(1, 0, 2'b11, 32'h0000_2000, 32'h0, 0); accept_now();
        send(1, 0, 2'b11, 32'h0000_2004, 32'h0, 0); accept_now();
        check("model_q2", q.size(), 2);
        flush = 1'b1; tick(); flush = 1'b0;
        check("model_cancel2", cancelled_cnt(), 2);
        resp(1'b0, "fl_dok1");
        resp(1'b0, "fl_dok2");
        send(1, 0, 2'b11, 32'h0000_2008, 32'h0, 0); accept_now();
        resp(1'b1, "fl_dok3");

        // Flush coinciding with data_ok, then back-pressure at MAX outstanding
        send(1, 0, 2'b11, 32'h0000_3000, 32'h0, 0); accept_now();
        send(1, 0, 2'b11, 32'h0000_3004, 32'h0, 0); accept_now();
        flush = 1'b1; data_sram_data_ok = 1'b1; #1;
        check("fd_dok", data_ok_valid, 1'b1);
        tick(); flush = 1'b0; data_sram_data_ok = 1'b0;
        check("model_cancel1", cancelled_cnt(), 1);
        send(1, 0, 2'b11, 32'h0000_3008, 32'h0, 0); accept_now();
        send(1, 0, 2'b11, 32'h0000_300C, 32'h0, 0);
        #1;
        check("full_req1", data_sram_req, 1'b0);
        tick(); #1;
        check("full_req2", data_sram_req, 1'b0);
        resp(1'b0, "full_dok_stale");
        #1;
        check("full_req3", data_sram_req, 1'b1);
        accept_now();
        resp(1'b1, "drain1");
        resp(1'b1, "drain2");

        // Reset while an issued request is outstanding and the stage is held
        out_allowin = 1'b0;
        send(0, 1, 2'b11, 32'h0000_4000, 32'hDEAD_BEEF, 0);
        accept_now();
        #1;
        check("pre_rst_allowin", in_allowin, 1'b0);
        resetn = 1'b0; tick(); resetn = 1'b1; #1;
        check("post_rst_req", data_sram_req, 1'b0);
        check("post_rst_allowin", in_allowin, 1'b1);
        check("post_rst_ov", out_valid, 1'b0);
        check("model_rst_q", q.size(), 0);
        out_allowin = 1'b1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
